cache_line_ctrl: RTL and testbench

Parametrised successor to the direct-mapped cache control FSM: sequences read hits, multi-word line fills on read misses, and write-through stores against a fixed-latency main memory. Sits between the CPU data port (Strobe/DRW/DReady) and the cache tag/data arrays plus memory bus. Generalises the existing controller with configurable memory wait states and line length, and adds per-word fill indexing.

---
 rtl/cache_ctrl_pkg.sv | 22 ++
 rtl/cache_line_ctrl_if.sv | 31 +++
 rtl/mem_wait_ctr.sv | 29 ++
 rtl/cache_line_ctrl.sv | 136 +++++++++++++
 tb/tb_cache_line_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding, widths and helpers for the direct-mapped cache line controller.
package cache_ctrl_pkg;

    localparam int STAT_W = 16;
    localparam int WAIT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_MISS,
        READ_MEM,
        READ_DATA,
        WRITE,
        WRITE_MEM,
        WRITE_DATA
    } state_t;

    function automatic int idx_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/cache_line_ctrl_if.sv
// CPU request, tag lookup, array and memory-bus signals of the cache line controller.
interface cache_line_ctrl_if #(
    parameter int LINE_WORDS = 1
);
    import cache_ctrl_pkg::*;

    localparam int IDX_W = idx_width(LINE_WORDS);

    logic             Strobe;
    logic             DRW;
    logic             M;
    logic             V;
    logic             DReady;
    logic             W;
    logic             MStrobe;
    logic             MRW;
    logic             RSel;
    logic             WSel;
    logic [IDX_W-1:0] FillIdx;

    modport master (
        input  Strobe, DRW, M, V,
        output DReady, W, MStrobe, MRW, RSel, WSel, FillIdx
    );

    modport slave (
        output Strobe, DRW, M, V,
        input  DReady, W, MStrobe, MRW, RSel, WSel, FillIdx
    );

endinterface

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter timing the memory wait states; holds at zero once drained.
module mem_wait_ctr
    import cache_ctrl_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == WIDTH'(1));

endmodule

// File: rtl/cache_line_ctrl.sv
// Direct-mapped cache controller: read hits, multi-word line fills, write-through stores.
// Optional hit/miss statistics outputs are enabled by defining CACHE_CTRL_STATS_EN.
module cache_line_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int LINE_WORDS  = 1
) (
    input  logic               clk,
    input  logic               reset,
    cache_line_ctrl_if.master  bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0]  HitCount,
    output logic [STAT_W-1:0]  MissCount
`endif
);

    localparam int               IDX_W    = idx_width(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  fill_idx;
    logic              hit_q;
    logic [WAIT_W-1:0] wait_val;
    logic              wait_done;
    logic              tag_hit;
    logic              last_word;

    assign tag_hit   = bus.M & bus.V;
    assign last_word = (fill_idx == LAST_IDX);

    mem_wait_ctr #(.WIDTH(WAIT_W)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (state == READ_MISS || state == WRITE),
        .load_val (WAIT_W'(WAIT_CYCLES)),
        .dec      (state == READ_MEM || state == WRITE_MEM),
        .value    (wait_val),
        .done     (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fill_idx <= '0;
            hit_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Strobe) state <= bus.DRW ? WRITE : READ;
                end
                READ: begin
                    if (tag_hit) begin
                        state <= IDLE;
                    end else begin
                        state    <= READ_MISS;
                        fill_idx <= '0;
                    end
                end
                READ_MISS: state <= READ_MEM;
                READ_MEM: begin
                    if (wait_done) state <= READ_DATA;
                end
                READ_DATA: begin
                    if (last_word) begin
                        state <= IDLE;
                    end else begin
                        state    <= READ_MISS;
                        fill_idx <= fill_idx + 1'b1;
                    end
                end
                WRITE: begin
                    hit_q <= tag_hit;
                    state <= WRITE_MEM;
                end
                // The write leg drains the counter to zero, one cycle past the read leg,
                // so a store completes WAIT_CYCLES+3 cycles after its request.
                WRITE_MEM: begin
                    if (wait_val == '0) state <= WRITE_DATA;
                end
                WRITE_DATA: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no latch can be inferred.
    always_comb begin
        bus.DReady  = 1'b0;
        bus.W       = 1'b0;
        bus.MStrobe = 1'b0;
        bus.MRW     = 1'b0;
        bus.RSel    = 1'b0;
        bus.WSel    = 1'b0;
        bus.FillIdx = fill_idx;
        case (state)
            READ:      bus.DReady = tag_hit;
            READ_MISS: bus.MStrobe = 1'b1;
            READ_DATA: begin
                bus.W      = 1'b1;
                bus.WSel   = 1'b1;
                bus.RSel   = 1'b1;
                bus.DReady = last_word;
            end
            WRITE: begin
                bus.MStrobe = 1'b1;
                bus.MRW     = 1'b1;
            end
            WRITE_MEM: bus.MRW = 1'b1;
            WRITE_DATA: begin
                bus.MRW    = 1'b1;
                bus.W      = hit_q;
                bus.DReady = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    // READ and WRITE are each visited exactly once per request, so they classify it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else if (state == READ || state == WRITE) begin
            if (tag_hit) begin
                if (HitCount != '1) HitCount <= HitCount + 1'b1;
            end else begin
                if (MissCount != '1) MissCount <= MissCount + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench for cache_line_ctrl: requests push expected bus events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_cache_line_ctrl;
    import cache_ctrl_pkg::*;

    localparam int WAIT_CYCLES = 4;
    localparam int LINE_WORDS  = 4;
    localparam int IDX_W       = idx_width(LINE_WORDS);
    localparam int WORD_T      = WAIT_CYCLES + 2;

    typedef struct packed {
        logic [31:0]      cyc;
        logic             ms;
        logic             mrw;
        logic             w;
        logic             wsel;
        logic             rsel;
        logic             dr;
        logic [IDX_W-1:0] idx;
    } ev_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    int               cyc   = 0;
    int               checks = 0;
    int               errors = 0;
    ev_t              exp_q[$];
    logic [IDX_W-1:0] exp_idx = '0;
    int               exp_hits = 0;
    int               exp_miss = 0;

`ifdef CACHE_CTRL_STATS_EN
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] miss_count;
`endif

    cache_line_ctrl_if #(.LINE_WORDS(LINE_WORDS)) bus ();

    cache_line_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .LINE_WORDS  (LINE_WORDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .HitCount  (hit_count),
        .MissCount (miss_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input logic ms, input logic mrw, input logic w,
                               input logic wsel, input logic rsel, input logic dr,
                               input logic [IDX_W-1:0] idx);
        ev_t e;
        e.cyc  = 32'(c);
        e.ms   = ms;
        e.mrw  = mrw;
        e.w    = w;
        e.wsel = wsel;
        e.rsel = rsel;
        e.dr   = dr;
        e.idx  = idx;
        return e;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.DReady, bus.W, bus.MStrobe, bus.MRW, bus.RSel, bus.WSel, bus.FillIdx});
    endfunction

    // Monitor: any cycle with bus activity must match the oldest expected event.
    always @(negedge clk) begin
        if (reset === 1'b1 && (bus.MStrobe || bus.W || bus.DReady || bus.MRW)) begin
            ev_t act;
            act = mk(cyc, bus.MStrobe, bus.MRW, bus.W, bus.WSel, bus.RSel, bus.DReady, bus.FillIdx);
            if (exp_q.size() == 0)
                check($sformatf("stray_event@%0d", cyc), 64'(act), 64'd0);
            else
                check($sformatf("event@%0d", cyc), 64'(act), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line fill issued at cycle t: word k strobes memory at t+2+k*WORD_T and is written
    // into the array WAIT_CYCLES+1 cycles later; the last word also completes the request.
    task automatic push_read_miss(input int t, input int n_ev);
        int pushed = 0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (pushed < n_ev) begin
                exp_q.push_back(mk(t + 2 + k * WORD_T, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDX_W'(k)));
                pushed++;
            end
            if (pushed < n_ev) begin
                exp_q.push_back(mk(t + 1 + (k + 1) * WORD_T, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                   (k == LINE_WORDS - 1), IDX_W'(k)));
                pushed++;
            end
        end
    endtask

    task automatic request(input logic wr, input logic m, input logic v);
        int   t;
        int   t_end;
        logic hit;
        t   = cyc;
        hit = m & v;
        if (hit) exp_hits++; else exp_miss++;
        if (!wr && hit) begin
            exp_q.push_back(mk(t + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_idx));
            t_end = t + 1;
        end else if (!wr) begin
            push_read_miss(t, 2 * LINE_WORDS);
            exp_idx = IDX_W'(LINE_WORDS - 1);
            t_end   = t + 1 + LINE_WORDS * WORD_T;
        end else begin
            exp_q.push_back(mk(t + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
            for (int j = 1; j <= WAIT_CYCLES + 1; j++)
                exp_q.push_back(mk(t + 1 + j, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_idx));
            exp_q.push_back(mk(t + WAIT_CYCLES + 3, 1'b0, 1'b1, hit, 1'b0, 1'b0, 1'b1, exp_idx));
            t_end = t + WAIT_CYCLES + 3;
        end
        bus.Strobe = 1'b1;
        bus.DRW    = wr;
        bus.M      = m;
        bus.V      = v;
        tick();
        bus.Strobe = 1'b0;
        tick();
        // While busy the controller must ignore every CPU-side input.
        while (cyc <= t_end) begin
            bus.Strobe = (cyc < t_end);
            bus.DRW    = 1'($urandom_range(0, 1));
            bus.M      = 1'($urandom_range(0, 1));
            bus.V      = 1'($urandom_range(0, 1));
            tick();
        end
        bus.Strobe = 1'b0;
        bus.DRW    = 1'b0;
        bus.M      = 1'b0;
        bus.V      = 1'b0;
    endtask

    initial begin
        int t;
        bus.Strobe = 1'b0;
        bus.DRW    = 1'b0;
        bus.M      = 1'b0;
        bus.V      = 1'b0;
        #2 reset = 1'b0;
        #1 check("reset_outputs", outs(), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        request(1'b0, 1'b1, 1'b1);   // read hit
        request(1'b1, 1'b1, 1'b1);   // write hit accepted back-to-back
        request(1'b0, 1'b0, 1'b1);   // read miss on tag mismatch
        request(1'b1, 1'b0, 1'b1);   // write miss
        request(1'b1, 1'b1, 1'b1);   // write hit
        request(1'b0, 1'b1, 1'b0);   // read miss on invalid line
        request(1'b0, 1'b1, 1'b1);   // read hit, FillIdx still holds last fill word

`ifdef CACHE_CTRL_STATS_EN
        check("hit_count", 64'(hit_count), 64'(exp_hits));
        check("miss_count", 64'(miss_count), 64'(exp_miss));
`endif

        // Reset during the third word's memory wait abandons the fill.
        t = cyc;
        push_read_miss(t, 5);
        bus.Strobe = 1'b1;
        bus.DRW    = 1'b0;
        bus.M      = 1'b0;
        bus.V      = 1'b1;
        tick();
        bus.Strobe = 1'b0;
        while (cyc < t + 16) tick();
        reset      = 1'b0;
        bus.Strobe = 1'b1;
        #1 check("reset_mid_fill_outputs", outs(), 64'd0);
        tick();
        tick();
        check("reset_hold_outputs", outs(), 64'd0);
        reset      = 1'b1;
        bus.Strobe = 1'b0;
        bus.M      = 1'b0;
        bus.V      = 1'b0;
        exp_idx    = '0;
        exp_hits   = 0;
        exp_miss   = 0;
        tick();
        check("fillidx_after_reset", 64'(bus.FillIdx), 64'd0);
        check("queue_after_reset", 64'(exp_q.size()), 64'd0);

        request(1'b0, 1'b1, 1'b1);   // controller idle again after reset
        request(1'b1, 1'b0, 1'b0);   // write miss after reset

`ifdef CACHE_CTRL_STATS_EN
        check("hit_count_post_reset", 64'(hit_count), 64'(exp_hits));
        check("miss_count_post_reset", 64'(miss_count), 64'(exp_miss));
`endif

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
